decode_stage: RTL and testbench

Pipeline decode (ID) stage of the in-order RV32I core. It sits between fetch and execute, drives the read addresses of the synchronous-read register file, and aligns the operands returned one cycle later with the decoded instruction. It also generates immediates, detects load-use hazards, and presents a registered ID/EX bundle to execute under a valid/ready handshake with stall and flush.

---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I in-order decode (ID) stage with load-use interlock
//
// Purpose: holds one fetched instruction in the D register while the
// synchronous register file returns its operands. It then presents a
// registered ID/EX bundle (decoded fields, sign-extended immediate and
// operand values) to execute under a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_valid/if_pc/if_inst   fetch side; transfer when if_valid && id_ready
//   id_ready                 decode can take an instruction this cycle
//   rs1_s/rs2_s              register-file read addresses
//   rs1_v/rs2_v              register-file read data (one cycle after address)
//   flush                    execute redirect, kills D and the ID/EX bundle
//   ex_ready                 execute accepts the ID/EX bundle
//   id_valid ... id_illegal  registered ID/EX bundle

module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        id_ready,
  output logic [4:0]  rs1_s,
  output logic [4:0]  rs2_s,
  input  logic [31:0] rs1_v,
  input  logic [31:0] rs2_v,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_rs1_v,
  output logic [31:0] id_rs2_v,
  output logic [4:0]  id_rs1_s,
  output logic [4:0]  id_rs2_s,
  output logic [4:0]  id_rd_s,
  output logic [31:0] id_imm,
  output logic        id_is_load,
  output logic        id_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // D register
  logic        r_d_valid;
  logic [31:0] r_d_pc;
  logic [31:0] r_d_inst;

  // ID/EX register
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_rs1_v;
  logic [31:0] r_id_rs2_v;
  logic [4:0]  r_id_rs1_s;
  logic [4:0]  r_id_rs2_s;
  logic [4:0]  r_id_rd_s;
  logic [31:0] r_id_imm;
  logic        r_id_is_load;
  logic        r_id_illegal;

  // Decode of the instruction held in D
  logic [6:0]  w_opc;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_has_rd;
  logic [31:0] w_imm;
  logic        w_is_load;
  logic        w_illegal;
  logic [4:0]  w_dec_rs1;
  logic [4:0]  w_dec_rs2;
  logic [4:0]  w_dec_rd;

  logic        w_load_use;
  logic        w_out_free;
  logic        w_d_advance;
  logic        w_d_load;

  assign w_opc   = r_d_inst[6:0];
  assign w_imm_i = {{20{r_d_inst[31]}}, r_d_inst[31:20]};
  assign w_imm_s = {{20{r_d_inst[31]}}, r_d_inst[31:25], r_d_inst[11:7]};
  assign w_imm_b = {{19{r_d_inst[31]}}, r_d_inst[31], r_d_inst[7],
                    r_d_inst[30:25], r_d_inst[11:8], 1'b0};
  assign w_imm_u = {r_d_inst[31:12], 12'b0};
  assign w_imm_j = {{11{r_d_inst[31]}}, r_d_inst[31], r_d_inst[19:12],
                    r_d_inst[20], r_d_inst[30:21], 1'b0};

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_has_rd  = 1'b0;
    w_imm     = 32'd0;
    w_is_load = 1'b0;
    w_illegal = 1'b0;
    case (w_opc)
      OP_REG: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_has_rd  = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        w_use_rs1 = 1'b1;
        w_has_rd  = 1'b1;
        w_imm     = w_imm_i;
      end
      OP_LOAD: begin
        w_use_rs1 = 1'b1;
        w_has_rd  = 1'b1;
        w_imm     = w_imm_i;
        w_is_load = 1'b1;
      end
      OP_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_s;
      end
      OP_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm     = w_imm_b;
      end
      OP_LUI, OP_AUIPC: begin
        w_has_rd  = 1'b1;
        w_imm     = w_imm_u;
      end
      OP_JAL: begin
        w_has_rd  = 1'b1;
        w_imm     = w_imm_j;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Unused fields read as x0 so they can never match a load destination
  assign w_dec_rs1 = w_use_rs1 ? r_d_inst[19:15] : 5'd0;
  assign w_dec_rs2 = w_use_rs2 ? r_d_inst[24:20] : 5'd0;
  assign w_dec_rd  = w_has_rd  ? r_d_inst[11:7]  : 5'd0;

  assign w_load_use = r_d_valid && r_id_valid && r_id_is_load && (r_id_rd_s != 5'd0) &&
                      ((r_id_rd_s == w_dec_rs1) || (r_id_rd_s == w_dec_rs2));

  assign w_out_free  = !r_id_valid || ex_ready;
  assign w_d_advance = r_d_valid && w_out_free && !w_load_use;
  assign id_ready    = flush || !r_d_valid || w_d_advance;
  assign w_d_load    = if_valid && id_ready && !flush;

  // While D is held, keep re-reading its sources so writebacks during a
  // stall land in the operands captured on the advance edge.
  assign rs1_s = w_d_load ? if_inst[19:15] : r_d_inst[19:15];
  assign rs2_s = w_d_load ? if_inst[24:20] : r_d_inst[24:20];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_valid    <= 1'b0;
      r_d_pc       <= 32'd0;
      r_d_inst     <= 32'd0;
      r_id_valid   <= 1'b0;
      r_id_pc      <= 32'd0;
      r_id_inst    <= 32'd0;
      r_id_rs1_v   <= 32'd0;
      r_id_rs2_v   <= 32'd0;
      r_id_rs1_s   <= 5'd0;
      r_id_rs2_s   <= 5'd0;
      r_id_rd_s    <= 5'd0;
      r_id_imm     <= 32'd0;
      r_id_is_load <= 1'b0;
      r_id_illegal <= 1'b0;
    end else if (flush) begin
      r_d_valid  <= 1'b0;
      r_id_valid <= 1'b0;
    end else begin
      if (w_d_load) begin
        r_d_valid <= 1'b1;
        r_d_pc    <= if_pc;
        r_d_inst  <= if_inst;
      end else if (w_d_advance) begin
        r_d_valid <= 1'b0;
      end

      if (w_d_advance) begin
        r_id_valid   <= 1'b1;
        r_id_pc      <= r_d_pc;
        r_id_inst    <= r_d_inst;
        r_id_rs1_v   <= rs1_v;
        r_id_rs2_v   <= rs2_v;
        r_id_rs1_s   <= w_dec_rs1;
        r_id_rs2_s   <= w_dec_rs2;
        r_id_rd_s    <= w_dec_rd;
        r_id_imm     <= w_imm;
        r_id_is_load <= w_is_load;
        r_id_illegal <= w_illegal;
      end else if (ex_ready) begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign id_valid   = r_id_valid;
  assign id_pc      = r_id_pc;
  assign id_inst    = r_id_inst;
  assign id_rs1_v   = r_id_rs1_v;
  assign id_rs2_v   = r_id_rs2_v;
  assign id_rs1_s   = r_id_rs1_s;
  assign id_rs2_s   = r_id_rs2_s;
  assign id_rd_s    = r_id_rd_s;
  assign id_imm     = r_id_imm;
  assign id_is_load = r_id_is_load;
  assign id_illegal = r_id_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage

module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ld;
    logic        ill;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic [31:0] if_inst = 32'd0;
  logic        id_ready;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [31:0] rs1_v = 32'd0;
  logic [31:0] rs2_v = 32'd0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_rs1_v;
  logic [31:0] id_rs2_v;
  logic [4:0]  id_rs1_s;
  logic [4:0]  id_rs2_s;
  logic [4:0]  id_rd_s;
  logic [31:0] id_imm;
  logic        id_is_load;
  logic        id_illegal;

  // register-file write port driven by the bench
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .id_ready   (id_ready),
    .rs1_s      (rs1_s),
    .rs2_s      (rs2_s),
    .rs1_v      (rs1_v),
    .rs2_v      (rs2_v),
    .flush      (flush),
    .ex_ready   (ex_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_rs1_v   (id_rs1_v),
    .id_rs2_v   (id_rs2_v),
    .id_rs1_s   (id_rs1_s),
    .id_rs2_s   (id_rs2_s),
    .id_rd_s    (id_rd_s),
    .id_imm     (id_imm),
    .id_is_load (id_is_load),
    .id_illegal (id_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Synchronous-read register file with same-cycle write bypass
  logic [31:0] arch [32] = '{default: 32'd0};
  logic [31:0] snap [32] = '{default: 32'd0};

  always @(posedge clk) begin
    rs1_v <= (wr_en && wr_addr != 5'd0 && wr_addr == rs1_s) ? wr_data : arch[rs1_s];
    rs2_v <= (wr_en && wr_addr != 5'd0 && wr_addr == rs2_s) ? wr_data : arch[rs2_s];
    if (wr_en && wr_addr != 5'd0) arch[wr_addr] <= wr_data;
  end

  // Reference decode straight from the RV32I format tables
  function automatic bundle_t ref_decode(input logic [31:0] pc, input logic [31:0] inst);
    bundle_t b;
    logic signed [31:0] s;
    b = '0;
    b.pc   = pc;
    b.inst = inst;
    s = inst;
    s = s >>> 20;
    case (inst[6:0])
      7'h33: begin b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.rd = inst[11:7]; end
      7'h13, 7'h67: begin b.rs1 = inst[19:15]; b.rd = inst[11:7]; b.imm = s; end
      7'h03: begin b.rs1 = inst[19:15]; b.rd = inst[11:7]; b.imm = s; b.ld = 1'b1; end
      7'h23: begin
        b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
        b.imm = (s & 32'hFFFF_FFE0) | {27'd0, inst[11:7]};
      end
      7'h63: begin
        b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
        b.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'h37, 7'h17: begin b.rd = inst[11:7]; b.imm = {inst[31:12], 12'd0}; end
      7'h6f: begin
        b.rd = inst[11:7];
        b.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: b.ill = 1'b1;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h0f, 7'h73};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 10)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // Transaction model: q holds the instruction sitting in D, m_out the bundle
  // execute should see. Updated once per clock from the previous cycle's inputs.
  bundle_t q [$];
  bundle_t m_out = '0;
  bit      m_valid = 1'b0;
  logic    p_rst = 1'b0, p_flush = 1'b0, p_ex_ready = 1'b0, p_if_valid = 1'b0, p_id_ready = 1'b0;
  logic [31:0] p_if_pc = 32'd0, p_if_inst = 32'd0;

  always @(negedge clk) begin
    bundle_t nb;
    bit hz, free, adv, m_ready;
    if (p_rst && rst) begin
      hz = (q.size() > 0) && m_valid && m_out.ld && (m_out.rd != 5'd0) &&
           ((q[0].rs1 == m_out.rd) || (q[0].rs2 == m_out.rd));
      free    = !m_valid || p_ex_ready;
      adv     = (q.size() > 0) && free && !hz;
      m_ready = p_flush || (q.size() == 0) || adv;
      check_val("id_ready", 32'(p_id_ready), 32'(m_ready));
      if (p_flush) begin
        q.delete();
        m_valid = 1'b0;
      end else begin
        if (adv) begin
          nb = q.pop_front();
          nb.v1 = snap[nb.inst[19:15]];
          nb.v2 = snap[nb.inst[24:20]];
          m_out = nb;
          m_valid = 1'b1;
        end else if (p_ex_ready) begin
          m_valid = 1'b0;
        end
        if (p_if_valid && m_ready) q.push_back(ref_decode(p_if_pc, p_if_inst));
      end
    end else begin
      q.delete();
      m_valid = 1'b0;
    end
    check_val("id_valid", 32'(id_valid), 32'(m_valid));
    if (m_valid) begin
      check_val("id_pc", id_pc, m_out.pc);
      check_val("id_inst", id_inst, m_out.inst);
      check_val("id_imm", id_imm, m_out.imm);
      check_val("id_rs1_v", id_rs1_v, m_out.v1);
      check_val("id_rs2_v", id_rs2_v, m_out.v2);
      check_val("id_rs1_s", 32'(id_rs1_s), 32'(m_out.rs1));
      check_val("id_rs2_s", 32'(id_rs2_s), 32'(m_out.rs2));
      check_val("id_rd_s", 32'(id_rd_s), 32'(m_out.rd));
      check_val("id_is_load", 32'(id_is_load), 32'(m_out.ld));
      check_val("id_illegal", 32'(id_illegal), 32'(m_out.ill));
    end
    p_rst      = rst;
    p_flush    = flush;
    p_ex_ready = ex_ready;
    p_if_valid = if_valid;
    p_id_ready = id_ready;
    p_if_pc    = if_pc;
    p_if_inst  = if_inst;
    snap       = arch;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] inst);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  // Fill the output register with addi x7 and park add x6,x5,x1 in D, ex_ready low
  task automatic fill_stalled(input logic [31:0] pc);
    ex_ready = 1'b0;
    feed(pc, 32'h0070_0393);
    step();
    feed(pc + 32'd4, 32'h0012_8333);
    step();
    if_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #1;
    check_val("rst_id_valid", 32'(id_valid), 32'd0);
    check_val("rst_id_ready", 32'(id_ready), 32'd1);
    check_val("rst_id_pc", id_pc, 32'd0);
    check_val("rst_id_imm", id_imm, 32'd0);
    step();
    step();
    rst = 1'b1;

    // single instruction: addi x1,x0,5
    ex_ready = 1'b1;
    feed(32'h0000_1000, 32'h0050_0093);
    step();
    if_valid = 1'b0;
    step();
    check_val("t1_valid", 32'(id_valid), 32'd1);
    check_val("t1_imm", id_imm, 32'd5);
    check_val("t1_rd", 32'(id_rd_s), 32'd1);
    check_val("t1_rs1", 32'(id_rs1_s), 32'd0);
    check_val("t1_rs2", 32'(id_rs2_s), 32'd0);
    check_val("t1_pc", id_pc, 32'h0000_1000);
    step();

    // load-use: lw x5,0(x2) then add x6,x5,x1
    feed(32'h0000_1100, 32'h0001_2283);
    step();
    feed(32'h0000_1104, 32'h0012_8333);
    step();
    if_valid = 1'b0;
    check_val("t2_lw_valid", 32'(id_valid), 32'd1);
    check_val("t2_lw_isload", 32'(id_is_load), 32'd1);
    check_val("t2_stall_ready", 32'(id_ready), 32'd0);
    step();
    check_val("t2_bubble", 32'(id_valid), 32'd0);
    step();
    check_val("t2_add_valid", 32'(id_valid), 32'd1);
    check_val("t2_add_rs1", 32'(id_rs1_s), 32'd5);
    check_val("t2_add_inst", id_inst, 32'h0012_8333);
    ex_ready = 1'b1;
    step();
    step();

    // backpressure with a writeback to x1 mid-stall
    fill_stalled(32'h0000_1200);
    for (int i = 0; i < 3; i++) begin
      check_val("t3_hold_inst", id_inst, 32'h0070_0393);
      check_val("t3_hold_ready", 32'(id_ready), 32'd0);
      wr_en   = (i == 0);
      wr_addr = 5'd1;
      wr_data = 32'hDEAD_0001;
      step();
    end
    wr_en = 1'b0;
    ex_ready = 1'b1;
    step();
    check_val("t3_add_inst", id_inst, 32'h0012_8333);
    check_val("t3_rs2_v", id_rs2_v, 32'hDEAD_0001);
    step();
    step();

    // immediate sign extension
    feed(32'h0000_3000, 32'hFE00_0EE3);
    step();
    feed(32'h0000_3004, 32'h8000_00EF);
    step();
    if_valid = 1'b0;
    check_val("t4_beq_imm", id_imm, 32'hFFFF_FFFC);
    check_val("t4_beq_rd", 32'(id_rd_s), 32'd0);
    step();
    check_val("t4_jal_imm", id_imm, 32'hFFF0_0000);
    check_val("t4_jal_rd", 32'(id_rd_s), 32'd1);
    step();

    // flush while stalled with D and output register full
    fill_stalled(32'h0000_4000);
    step();
    flush = 1'b1;
    feed(32'h0000_4100, 32'h0090_0493);
    #1;
    check_val("t5_flush_ready", 32'(id_ready), 32'd1);
    step();
    flush = 1'b0;
    if_valid = 1'b0;
    check_val("t5_post_valid", 32'(id_valid), 32'd0);
    check_val("t5_post_ready", 32'(id_ready), 32'd1);
    ex_ready = 1'b1;
    step();
    step();
    check_val("t5_nothing_issued", 32'(id_valid), 32'd0);

    // asynchronous reset while id_valid is high
    ex_ready = 1'b0;
    feed(32'h0000_5000, 32'h0050_0093);
    step();
    if_valid = 1'b0;
    step();
    check_val("t6_pre_valid", 32'(id_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_async_valid", 32'(id_valid), 32'd0);
    check_val("t6_async_pc", id_pc, 32'd0);
    step();
    step();
    rst = 1'b1;
    ex_ready = 1'b1;
    feed(32'h0000_2000, 32'h0050_0093);
    step();
    if_valid = 1'b0;
    step();
    check_val("t6_first_valid", 32'(id_valid), 32'd1);
    check_val("t6_first_pc", id_pc, 32'h0000_2000);
    step();

    // randomized traffic, checked by the model above
    for (int c = 0; c < 3000; c++) begin
      if_valid = ($urandom_range(0, 9) < 7);
      if_pc    = 32'h0001_0000 + 32'(c) * 32'd4;
      if_inst  = gen_inst();
      ex_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 39) == 0);
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      step();
    end
    if_valid = 1'b0;
    flush    = 1'b0;
    wr_en    = 1'b0;
    ex_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
